sdram_sample_reader: RTL and testbench

Avalon-MM read master that fetches a block of 32-bit filtered samples from SDRAM, which the notch filter wrote there, and streams them out in order on a valid/ready source port for playback. Pipelined reads use readdatavalid, with credit-based flow control into an internal FIFO. Nios controls the block through a small Avalon-MM slave register file and is notified by a sticky IRQ when the whole block has been delivered.

---
 rtl/sample_reader_pkg.sv | 33 +++
 rtl/sample_fifo.sv | 69 ++++++
 rtl/sample_reader_checker.sv | 22 ++
 rtl/sdram_sample_reader.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_sdram_sample_reader.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_reader_pkg.sv
// Shared definitions for the SDRAM sample reader: register map, CTRL/STATUS
// bit positions and the controller state encoding.
package sample_reader_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_BASE      = 3'd1;
  localparam logic [2:0] REG_COUNT     = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_DELIVERED = 3'd4;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_LOOP_BIT   = 2;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_IRQ_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_e;

  // Pack the STATUS register read value.
  function automatic logic [31:0] status_word(input logic busy, input logic irq_flag);
    logic [31:0] v;
    v = 32'd0;
    v[STATUS_BUSY_BIT] = busy;
    v[STATUS_IRQ_BIT]  = irq_flag;
    return v;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for returned samples. Head word is visible on o_data
// while not empty; push and pop in the same cycle are legal at any level.
// A push into a full FIFO without a simultaneous pop is dropped.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == {LW{1'b0}});
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array write port; flush only moves the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Read/write pointers and fill level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   r_level <= r_level - {{(LW-1){1'b0}}, 1'b1};
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sample_reader_checker.sv
// Protocol and credit checks for the sample reader: no FIFO overflow and a
// stalled Avalon read request holds its address and read strobe.
module sample_reader_checker #(
  parameter int ADDR_W = 24
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_push,
  input logic              i_pop,
  input logic              i_full,
  input logic              i_avm_read,
  input logic              i_avm_waitrequest,
  input logic [ADDR_W-1:0] i_avm_address
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && i_full && !i_pop));

  a_stall_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_avm_read && i_avm_waitrequest) |=> (i_avm_read && $stable(i_avm_address)));

endmodule

// File: rtl/sdram_sample_reader.sv
// Avalon-MM read master streaming a block of 32-bit samples from SDRAM to a
// valid/ready source, with credit-limited pipelined reads, a small register
// file and a sticky completion IRQ.
// Optional build macro SAMPLE_READER_LOOP_EN: CTRL bit2 latched at start
// makes the block replay the same buffer until aborted.
module sdram_sample_reader
  import sample_reader_pkg::*;
#(
  parameter int          ADDR_W          = 24,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [31:0] DEFAULT_COUNT   = 32'd963144
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              irq
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  reader_state_e     r_state;
  reader_state_e     w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_avm_read;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_count;
  logic [31:0]       r_issued;
  logic [31:0]       r_delivered;
  logic [OUT_W-1:0]  r_outstanding;
  logic              r_irq;
  logic [31:0]       r_readdata;
`ifdef SAMPLE_READER_LOOP_EN
  logic              r_loop;
  logic              w_loop_nxt;
`endif

  logic              w_busy;
  logic              w_start;
  logic              w_abort;
  logic              w_accept;
  logic              w_hold;
  logic              w_rdv;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [LVL_W-1:0]  w_fifo_level;
  logic [LVL_W-1:0]  w_level_inc;
  logic [OUT_W-1:0]  w_outst_inc;
  logic [31:0]       w_issued_inc;
  logic [31:0]       w_delivered_inc;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_issue_ok;
  logic              w_read_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [31:0]       w_issued_nxt;
  logic [31:0]       w_delivered_nxt;
  logic [OUT_W-1:0]  w_outst_nxt;
  logic              w_irq_set;
  logic              w_flush;

  assign w_busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_start   = avs_write && (avs_address == REG_CTRL) && avs_writedata[CTRL_START_BIT];
  assign w_abort   = avs_write && (avs_address == REG_CTRL) && avs_writedata[CTRL_ABORT_BIT];
  assign w_accept  = r_avm_read & ~avm_waitrequest;
  assign w_hold    = r_avm_read & avm_waitrequest;
  // Returns are only meaningful while a transfer is active; anything else is stale.
  assign w_rdv     = avm_readdatavalid && w_busy && (r_outstanding != {OUT_W{1'b0}});
  assign w_push    = w_rdv && (r_state == ST_RUN);
  assign w_pop     = ~w_fifo_empty & src_ready;

  assign w_issued_inc    = r_issued + {31'd0, w_accept};
  assign w_delivered_inc = r_delivered + {31'd0, w_pop};
  assign w_addr_inc      = w_accept ? (r_addr + ADDR_W'(3'd4)) : r_addr;

  // Counter values after this edge, used to decide whether the next cycle may issue.
  always_comb begin
    w_outst_inc = r_outstanding;
    case ({w_accept, w_rdv})
      2'b10:   w_outst_inc = r_outstanding + {{(OUT_W-1){1'b0}}, 1'b1};
      2'b01:   w_outst_inc = r_outstanding - {{(OUT_W-1){1'b0}}, 1'b1};
      default: w_outst_inc = r_outstanding;
    endcase
    w_level_inc = w_fifo_level;
    case ({w_push, w_pop})
      2'b10:   w_level_inc = w_fifo_level + {{(LVL_W-1){1'b0}}, 1'b1};
      2'b01:   w_level_inc = w_fifo_level - {{(LVL_W-1){1'b0}}, 1'b1};
      default: w_level_inc = w_fifo_level;
    endcase
    // Credits: every read in flight reserves one FIFO slot.
    w_issue_ok = (w_issued_inc < r_count)
              && (32'(w_outst_inc) < 32'(MAX_OUTSTANDING))
              && ((32'(w_outst_inc) + 32'(w_level_inc)) < 32'(FIFO_DEPTH));
  end

  // Next-state and datapath-update decode for the controller FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_read_nxt      = 1'b0;
    w_addr_nxt      = w_addr_inc;
    w_issued_nxt    = w_issued_inc;
    w_delivered_nxt = w_delivered_inc;
    w_outst_nxt     = w_outst_inc;
    w_irq_set       = 1'b0;
    w_flush         = 1'b0;
`ifdef SAMPLE_READER_LOOP_EN
    w_loop_nxt      = r_loop;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (r_count != 32'd0) begin
            w_state_nxt     = ST_RUN;
            w_addr_nxt      = r_base;
            w_issued_nxt    = 32'd0;
            w_delivered_nxt = 32'd0;
            w_outst_nxt     = {OUT_W{1'b0}};
`ifdef SAMPLE_READER_LOOP_EN
            w_loop_nxt      = avs_writedata[CTRL_LOOP_BIT];
`endif
          end else begin
            w_state_nxt = ST_DONE;
            w_irq_set   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          // A request already presented must stay up until the slave takes it.
          w_state_nxt = ST_DRAIN;
          w_read_nxt  = w_hold;
        end else if (r_delivered == r_count) begin
          w_irq_set = 1'b1;
`ifdef SAMPLE_READER_LOOP_EN
          if (r_loop) begin
            w_state_nxt     = ST_RUN;
            w_addr_nxt      = r_base;
            w_issued_nxt    = 32'd0;
            w_delivered_nxt = 32'd0;
          end else begin
            w_state_nxt = ST_DONE;
          end
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_state_nxt = ST_RUN;
          w_read_nxt  = w_hold | w_issue_ok;
        end
      end
      ST_DRAIN: begin
        w_read_nxt = w_hold;
        if ((r_outstanding == {OUT_W{1'b0}}) && !r_avm_read) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read-master address, strobe and transfer counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr        <= {ADDR_W{1'b0}};
      r_avm_read    <= 1'b0;
      r_issued      <= 32'd0;
      r_delivered   <= 32'd0;
      r_outstanding <= {OUT_W{1'b0}};
`ifdef SAMPLE_READER_LOOP_EN
      r_loop        <= 1'b0;
`endif
    end else begin
      r_addr        <= w_addr_nxt;
      r_avm_read    <= w_read_nxt;
      r_issued      <= w_issued_nxt;
      r_delivered   <= w_delivered_nxt;
      r_outstanding <= w_outst_nxt;
`ifdef SAMPLE_READER_LOOP_EN
      r_loop        <= w_loop_nxt;
`endif
    end
  end

  // Slave register file, sticky IRQ and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base     <= {ADDR_W{1'b0}};
      r_count    <= DEFAULT_COUNT;
      r_irq      <= 1'b0;
      r_readdata <= 32'd0;
    end else begin
      if (avs_write && (avs_address == REG_BASE) && !w_busy) begin
        r_base <= {avs_writedata[ADDR_W-1:2], 2'b00};
      end
      if (avs_write && (avs_address == REG_COUNT) && !w_busy) begin
        r_count <= avs_writedata;
      end
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (avs_write && (avs_address == REG_STATUS) && avs_writedata[STATUS_IRQ_BIT]) begin
        r_irq <= 1'b0;
      end
      if (avs_read) begin
        case (avs_address)
          REG_BASE:      r_readdata <= 32'(r_base);
          REG_COUNT:     r_readdata <= r_count;
          REG_STATUS:    r_readdata <= status_word(w_busy, r_irq);
          REG_DELIVERED: r_readdata <= r_delivered;
          default:       r_readdata <= 32'd0;
        endcase
      end
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (avm_readdata),
    .o_data  (src_data),
    .o_level (w_fifo_level),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  sample_reader_checker #(
    .ADDR_W (ADDR_W)
  ) u_checker (
    .i_clk             (clk),
    .i_rst             (reset),
    .i_push            (w_push),
    .i_pop             (w_pop),
    .i_full            (w_fifo_full),
    .i_avm_read        (r_avm_read),
    .i_avm_waitrequest (avm_waitrequest),
    .i_avm_address     (r_addr)
  );

  assign avm_address  = r_addr;
  assign avm_read     = r_avm_read;
  assign avs_readdata = r_readdata;
  assign src_valid    = ~w_fifo_empty;
  assign irq          = r_irq;

endmodule

// File: tb/tb_sdram_sample_reader.sv
// Scoreboard bench for sdram_sample_reader: an SDRAM slave model with a
// fixed 3-cycle return latency and optional random waitrequest, a sink
// model, and a queue of expected samples filled at each start.
module tb_sdram_sample_reader;

  localparam int ADDR_W = 24;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;
  logic [2:0]        avs_address;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;
  logic              irq;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_recv = 0;
  int          acc_mark = 0;
  int          recv_mark = 0;
  int          wait_mode = 0;
  int          ready_mode = 1;
  logic [31:0] tb_base = 32'h100;
  logic [31:0] exp_q[$];

  sdram_sample_reader dut (
    .clk               (clk),
    .reset             (reset),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .irq               (irq)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // SDRAM slave and sink model: requests sampled on the falling edge, returns driven after the rising edge.
  initial begin
    logic [ADDR_W-1:0] pipe_a [3];
    logic              pipe_v [3];
    logic              pend_v;
    logic [ADDR_W-1:0] pend_a;
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       want;
    for (int i = 0; i < 3; i++) begin
      pipe_a[i] = '0;
      pipe_v[i] = 1'b0;
    end
    pend_a = '0;
    prev_stall = 1'b0;
    prev_addr = '0;
    avm_readdata = 32'd0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    src_ready = 1'b0;
    forever begin
      @(negedge clk);
      pend_v = 1'b0;
      if (!reset) begin
        if (prev_stall) begin
          chk_eq("stall_read", 32'(avm_read), 32'd1);
          chk_eq("stall_addr", 32'(avm_address), 32'(prev_addr));
        end
        if (avm_read && !avm_waitrequest) begin
          want = (tb_base + 32'(4 * (n_acc - acc_mark))) & 32'h00FF_FFFF;
          chk_eq("req_addr", 32'(avm_address), want);
          n_acc++;
          pend_v = 1'b1;
          pend_a = avm_address;
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr = avm_address;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      pipe_v[2] = pipe_v[1];
      pipe_a[2] = pipe_a[1];
      pipe_v[1] = pipe_v[0];
      pipe_a[1] = pipe_a[0];
      pipe_v[0] = pend_v;
      pipe_a[0] = pend_a;
      avm_readdatavalid = pipe_v[2];
      avm_readdata = (32'(pipe_a[2]) - tb_base) >> 2;
      avm_waitrequest = (wait_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ready_mode == 2) begin
        src_ready = 1'($urandom_range(0, 1));
      end else begin
        src_ready = (ready_mode == 1);
      end
    end
  end

  // Sink monitor: every accepted sample is compared against the scoreboard head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("sample_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk_eq("sample", src_data, e);
        end
        n_recv++;
      end
    end
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    tick(1);
    avs_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    tick(1);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int k;
    k = 0;
    while (!irq && k < budget) begin
      tick(1);
      k++;
    end
    chk_eq(tag, 32'(irq), 32'd1);
  endtask

  task automatic run_start(input logic [31:0] base, input int count);
    tb_base = base;
    acc_mark = n_acc;
    recv_mark = n_recv;
    exp_q.delete();
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(32'(i));
    end
    reg_wr(3'd1, base);
    reg_wr(3'd2, 32'(count));
    reg_wr(3'd0, 32'd1);
  endtask

  // Main stimulus sequence.
  initial begin
    logic [31:0] rd;
    int          snap;
    int          k;
    reset = 1'b1;
    avs_address = 3'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = 32'd0;
    tick(3);
    reset = 1'b0;
    chk_eq("rst_avm_read", 32'(avm_read), 32'd0);
    chk_eq("rst_avm_addr", 32'(avm_address), 32'd0);
    chk_eq("rst_src_valid", 32'(src_valid), 32'd0);
    chk_eq("rst_irq", 32'(irq), 32'd0);
    chk_eq("rst_readdata", avs_readdata, 32'd0);
    reg_rd(3'd2, rd); chk_eq("rst_count", rd, 32'd963144);
    reg_rd(3'd1, rd); chk_eq("rst_base", rd, 32'd0);
    reg_rd(3'd3, rd); chk_eq("rst_status", rd, 32'd0);

    // Basic block of 20 samples, zero-wait SDRAM.
    reg_wr(3'd1, 32'h103);
    reg_rd(3'd1, rd); chk_eq("base_mask", rd, 32'h100);
    ready_mode = 1;
    run_start(32'h100, 20);
    wait_irq("t1_irq", 400);
    chk_eq("t1_recv_at_irq", 32'(n_recv - recv_mark), 32'd20);
    chk_eq("t1_acc", 32'(n_acc - acc_mark), 32'd20);
    tick(2);
    reg_rd(3'd3, rd); chk_eq("t1_status", rd, 32'h2);
    reg_rd(3'd4, rd); chk_eq("t1_delivered", rd, 32'd20);
    reg_rd(3'd5, rd); chk_eq("unused_addr", rd, 32'd0);
    reg_rd(3'd4, rd);
    reg_rd(3'd0, rd); chk_eq("ctrl_read", rd, 32'd0);
    reg_wr(3'd3, 32'h2);
    chk_eq("t1_w1c_irq", 32'(irq), 32'd0);
    reg_rd(3'd3, rd); chk_eq("t1_w1c_status", rd, 32'd0);

    // Sink stalled: credits must stop issue at exactly FIFO_DEPTH reads.
    ready_mode = 0;
    run_start(32'h100, 40);
    tick(80);
    chk_eq("t2_issued_cap", 32'(n_acc - acc_mark), 32'd16);
    chk_eq("t2_read_low", 32'(avm_read), 32'd0);
    chk_eq("t2_src_valid", 32'(src_valid), 32'd1);
    ready_mode = 1;
    wait_irq("t2_irq", 1000);
    chk_eq("t2_recv", 32'(n_recv - recv_mark), 32'd40);
    chk_eq("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    reg_wr(3'd3, 32'h2);

    // Random waitrequest and random sink backpressure.
    wait_mode = 1;
    ready_mode = 2;
    run_start(32'h100, 30);
    wait_irq("t3_irq", 3000);
    chk_eq("t3_recv", 32'(n_recv - recv_mark), 32'd30);
    chk_eq("t3_acc", 32'(n_acc - acc_mark), 32'd30);
    reg_wr(3'd3, 32'h2);
    wait_mode = 0;
    ready_mode = 1;
    tick(3);

    // Abort after 5 samples with reads in flight.
    run_start(32'h100, 40);
    k = 0;
    while ((n_recv - recv_mark) < 5 && k < 300) begin
      tick(1);
      k++;
    end
    chk_eq("t4_pre_samples", 32'((n_recv - recv_mark) >= 5), 32'd1);
    reg_wr(3'd0, 32'h2);
    snap = n_acc;
    tick(20);
    chk_eq("t4_no_new_reads", 32'(n_acc), 32'(snap));
    chk_eq("t4_read_low", 32'(avm_read), 32'd0);
    chk_eq("t4_fifo_empty", 32'(src_valid), 32'd0);
    chk_eq("t4_irq", 32'(irq), 32'd0);
    reg_rd(3'd3, rd); chk_eq("t4_status", rd, 32'd0);
    exp_q.delete();

    // COUNT=0 completes immediately without reads.
    reg_wr(3'd2, 32'd0);
    snap = n_acc;
    reg_wr(3'd0, 32'd1);
    chk_eq("t5_zero_irq", 32'(irq), 32'd1);
    chk_eq("t5_zero_read", 32'(avm_read), 32'd0);
    tick(5);
    chk_eq("t5_zero_no_acc", 32'(n_acc), 32'(snap));
    reg_wr(3'd3, 32'h2);

    // Second start and COUNT write while running are ignored.
    ready_mode = 0;
    run_start(32'h200, 12);
    tick(30);
    reg_wr(3'd2, 32'd50);
    reg_wr(3'd0, 32'd1);
    reg_rd(3'd3, rd); chk_eq("t5_busy", rd, 32'h1);
    ready_mode = 1;
    wait_irq("t5_irq", 500);
    tick(2);
    chk_eq("t5_recv", 32'(n_recv - recv_mark), 32'd12);
    chk_eq("t5_acc", 32'(n_acc - acc_mark), 32'd12);
    reg_rd(3'd2, rd); chk_eq("t5_count", rd, 32'd12);

    // Asynchronous reset mid-run, with irq still set from the last block.
    run_start(32'h100, 40);
    tick(8);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_eq("t6_rst_read", 32'(avm_read), 32'd0);
    chk_eq("t6_rst_valid", 32'(src_valid), 32'd0);
    chk_eq("t6_rst_irq", 32'(irq), 32'd0);
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    tick(10);
    chk_eq("t6_post_valid", 32'(src_valid), 32'd0);
    chk_eq("t6_post_read", 32'(avm_read), 32'd0);
    reg_rd(3'd2, rd); chk_eq("t6_count", rd, 32'd963144);
    reg_rd(3'd1, rd); chk_eq("t6_base", rd, 32'd0);
    reg_rd(3'd4, rd); chk_eq("t6_delivered", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
